lc3_term_dev: RTL and testbench

- Terminal device model and pad-side peer of the LC-3 core's memory-mapped keyboard/display pads.
- Keyboard side: host-supplied characters are buffered and offered to the core via KBDR/KBSR handshakes.
- Display side: characters the core writes to DDR are captured via DSR handshakes and buffered for the host.
- Used in the top-level bench and in the FPGA wrapper, wired directly to the core pads.

---
 rtl/lc3_term_dev.sv | 147 ++++++++++++++
 tb/tb_lc3_term_dev.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lc3_term_dev.sv
// lc3_term_dev: terminal peer of the LC-3 keyboard/display pads, buffering keys in and display characters out
module lc3_term_dev #(
  parameter int KEY_DEPTH   = 8,
  parameter int DISP_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          key_vld,
  output logic                          key_rdy,
  input  logic [7:0]                    key_data,
  output logic                          disp_vld,
  input  logic                          disp_rdy,
  output logic [7:0]                    disp_data,
  input  logic [15:0]                   cpu_kbsr,
  input  logic [15:0]                   cpu_ddr,
  input  logic [15:0]                   cpu_out_dsr,
  output logic [15:0]                   term_kbdr,
  output logic [15:0]                   term_in_dsr,
  output logic [$clog2(KEY_DEPTH):0]    key_level,
  output logic [$clog2(DISP_DEPTH):0]   disp_level
);
  localparam int KAW = $clog2(KEY_DEPTH);
  localparam int DAW = $clog2(DISP_DEPTH);

  typedef enum logic [1:0] {K_IDLE, K_OFFER, K_WAIT} k_state_t;
  typedef enum logic [1:0] {D_SYNC, D_READY, D_ACK} d_state_t;

  logic [9:0] sync_q [SYNC_STAGES];
  logic       ks, ds;
  logic [7:0] dd;
  logic       unused_pads;

  logic [7:0]     key_mem [KEY_DEPTH];
  logic [KAW-1:0] key_wp, key_rp;
  logic [KAW:0]   key_cnt;
  logic           key_push, key_pop;

  logic [7:0]     disp_mem [DISP_DEPTH];
  logic [DAW-1:0] disp_wp, disp_rp;
  logic [DAW:0]   disp_cnt;
  logic           disp_push, disp_pop, disp_full;

  k_state_t   k_state, k_next;
  d_state_t   d_state, d_next;
  logic       kbdr_stb, dsr_rdy;
  logic [7:0] kbdr_chr;

  assign unused_pads = ^{cpu_kbsr[14:0], cpu_ddr[15:8], cpu_out_dsr[14:0]};

  // Status bits and the character share one chain so dd is aligned with ds at capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {cpu_kbsr[15], cpu_out_dsr[15], cpu_ddr[7:0]};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end

  assign {ks, ds, dd} = sync_q[SYNC_STAGES-1];

  assign key_rdy   = rst_n && (key_cnt != (KAW+1)'(KEY_DEPTH));
  assign key_push  = key_vld && key_rdy;
  assign key_level = key_cnt;

  always_ff @(posedge clk)
    if (key_push) key_mem[key_wp] <= key_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_wp  <= '0;
      key_rp  <= '0;
      key_cnt <= '0;
    end else begin
      key_wp  <= key_push ? key_wp + KAW'(1) : key_wp;
      key_rp  <= key_pop ? key_rp + KAW'(1) : key_rp;
      key_cnt <= key_cnt + (KAW+1)'(key_push) - (KAW+1)'(key_pop);
    end

  assign disp_full  = disp_cnt == (DAW+1)'(DISP_DEPTH);
  assign disp_vld   = disp_cnt != '0;
  assign disp_pop   = disp_vld && disp_rdy;
  assign disp_data  = disp_mem[disp_rp];
  assign disp_level = disp_cnt;

  always_ff @(posedge clk)
    if (disp_push) disp_mem[disp_wp] <= dd;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      disp_wp  <= '0;
      disp_rp  <= '0;
      disp_cnt <= '0;
    end else begin
      disp_wp  <= disp_push ? disp_wp + DAW'(1) : disp_wp;
      disp_rp  <= disp_pop ? disp_rp + DAW'(1) : disp_rp;
      disp_cnt <= disp_cnt + (DAW+1)'(disp_push) - (DAW+1)'(disp_pop);
    end

  always_comb begin
    k_next  = k_state;
    key_pop = 1'b0;
    case (k_state)
      K_IDLE:  k_next = (key_cnt != '0 && !ks) ? K_OFFER : K_IDLE;
      K_OFFER: begin
        key_pop = ks;
        k_next  = ks ? K_WAIT : K_OFFER;
      end
      K_WAIT:  k_next = ks ? K_WAIT : K_IDLE;
      default: k_next = K_IDLE;
    endcase
  end

  // Only entry into D_READY requires space, so a push in D_READY always fits
  always_comb begin
    d_next    = d_state;
    disp_push = 1'b0;
    case (d_state)
      D_SYNC:  d_next = (ds && !disp_full) ? D_READY : D_SYNC;
      D_READY: begin
        disp_push = !ds;
        d_next    = ds ? D_READY : D_ACK;
      end
      D_ACK:   d_next = ds ? D_SYNC : D_ACK;
      default: d_next = D_SYNC;
    endcase
  end

  // The strobe trails K_OFFER entry by one cycle and drops with the pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k_state  <= K_IDLE;
      d_state  <= D_SYNC;
      kbdr_stb <= 1'b0;
      kbdr_chr <= '0;
      dsr_rdy  <= 1'b0;
    end else begin
      k_state  <= k_next;
      d_state  <= d_next;
      kbdr_stb <= k_state == K_OFFER && !ks;
      kbdr_chr <= k_state == K_OFFER ? key_mem[key_rp] : kbdr_chr;
      dsr_rdy  <= d_next == D_READY;
    end

  assign term_kbdr   = {kbdr_stb, 7'b0, kbdr_chr};
  assign term_in_dsr = {dsr_rdy, 15'b0};
endmodule

// File: tb/tb_lc3_term_dev.sv
// tb_lc3_term_dev: directed bench for lc3_term_dev, playing both host and LC-3 core pad sides
module tb_lc3_term_dev;
  logic        clk = 1'b0, rst_n = 1'b0, key_vld = 1'b0, disp_rdy = 1'b0;
  logic [7:0]  key_data = '0;
  logic [15:0] cpu_kbsr = '0, cpu_ddr = '0, cpu_out_dsr = 16'h8000;
  logic        key_rdy, disp_vld;
  logic [7:0]  disp_data;
  logic [15:0] term_kbdr, term_in_dsr;
  logic [3:0]  key_level, disp_level;
  int checks = 0, errors = 0;

  lc3_term_dev dut (
    .clk(clk), .rst_n(rst_n), .key_vld(key_vld), .key_rdy(key_rdy), .key_data(key_data),
    .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_data(disp_data),
    .cpu_kbsr(cpu_kbsr), .cpu_ddr(cpu_ddr), .cpu_out_dsr(cpu_out_dsr),
    .term_kbdr(term_kbdr), .term_in_dsr(term_in_dsr),
    .key_level(key_level), .disp_level(disp_level)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_offer(output logic [7:0] c, output bit ok);
    ok = 0; c = '0;
    for (int i = 0; i < 20 && !ok; i++)
      if (term_kbdr[15]) begin ok = 1; c = term_kbdr[7:0]; end else tick(1);
  endtask

  task automatic wait_dsr(input logic v, output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++)
      if (term_in_dsr[15] === v) ok = 1; else tick(1);
  endtask

  task automatic core_write(input logic [7:0] ch, output bit ok);
    wait_dsr(1'b1, ok);
    if (!ok) return;
    cpu_ddr = {8'h00, ch}; cpu_out_dsr = 16'h0000;
    wait_dsr(1'b0, ok);
    cpu_out_dsr = 16'h8000;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (term_kbdr !== 16'h0000) begin errors++; $display("FAIL reset_kbdr: got %h want 0000", term_kbdr); end
    checks++; if (term_in_dsr !== 16'h0000) begin errors++; $display("FAIL reset_dsr: got %h want 0000", term_in_dsr); end
    checks++; if ({key_rdy, disp_vld, key_level, disp_level} !== 10'd0) begin errors++; $display("FAIL reset_flags: rdy=%b vld=%b kl=%0d dl=%0d want all 0", key_rdy, disp_vld, key_level, disp_level); end
    tick(2); rst_n = 1'b1; tick(1);
    checks++; if (key_rdy !== 1'b1) begin errors++; $display("FAIL reset_key_rdy: got %b want 1", key_rdy); end
  endtask

  task automatic test_single_key;
    key_vld = 1'b1; key_data = 8'h41; tick(1); key_vld = 1'b0;
    checks++; if (key_level !== 4'd1) begin errors++; $display("FAIL k1_level: got %0d want 1", key_level); end
    tick(1);
    checks++; if (term_kbdr !== 16'h0000) begin errors++; $display("FAIL k1_early: got %h want 0000", term_kbdr); end
    tick(1);
    checks++; if (term_kbdr !== 16'h8041) begin errors++; $display("FAIL k1_offer: got %h want 8041", term_kbdr); end
    tick(2); cpu_kbsr = 16'h8000; tick(5);
    checks++; if (term_kbdr !== 16'h0041) begin errors++; $display("FAIL k1_wait: got %h want 0041", term_kbdr); end
    checks++; if (key_level !== 4'd0) begin errors++; $display("FAIL k1_pop_level: got %0d want 0", key_level); end
    cpu_kbsr = 16'h0000; tick(5);
    checks++; if (term_kbdr !== 16'h0041) begin errors++; $display("FAIL k1_no_reoffer: got %h want 0041", term_kbdr); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] c;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      key_vld = 1'b1; key_data = 8'h61 + 8'(i); tick(1);
      checks++; if (key_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy%0d: got %b want 1", i, key_rdy); end
    end
    key_vld = 1'b0;
    checks++; if (key_level !== 4'd3) begin errors++; $display("FAIL b2b_level: got %0d want 3", key_level); end
    for (int i = 0; i < 3; i++) begin
      wait_offer(c, ok);
      checks++; if (!ok || c !== 8'h61 + 8'(i)) begin errors++; $display("FAIL b2b_char%0d: got %h (offered=%b) want %h", i, c, ok, 8'h61 + 8'(i)); end
      tick(2); cpu_kbsr = 16'h8000; tick(5);
      checks++; if (term_kbdr[15] !== 1'b0) begin errors++; $display("FAIL b2b_hold%0d: strobe %b want 0", i, term_kbdr[15]); end
      cpu_kbsr = 16'h0000; tick(3);
    end
    checks++; if (key_level !== 4'd0) begin errors++; $display("FAIL b2b_empty: got %0d want 0", key_level); end
  endtask

  task automatic test_display;
    bit ok;
    wait_dsr(1'b1, ok);
    checks++; if (!ok || term_in_dsr !== 16'h8000) begin errors++; $display("FAIL d_ready: got %h want 8000", term_in_dsr); end
    cpu_ddr = 16'h0048; cpu_out_dsr = 16'h0000; tick(2);
    checks++; if (term_in_dsr !== 16'h8000) begin errors++; $display("FAIL d_sync_delay: got %h want 8000", term_in_dsr); end
    tick(1);
    checks++; if (term_in_dsr !== 16'h0000) begin errors++; $display("FAIL d_ack: got %h want 0000", term_in_dsr); end
    checks++; if (disp_vld !== 1'b1 || disp_data !== 8'h48) begin errors++; $display("FAIL d_capture: vld=%b data=%h want 1/48", disp_vld, disp_data); end
    cpu_out_dsr = 16'h8000; tick(3);
    checks++; if (term_in_dsr !== 16'h0000) begin errors++; $display("FAIL d_ack_hold: got %h want 0000", term_in_dsr); end
    tick(1);
    checks++; if (term_in_dsr !== 16'h8000) begin errors++; $display("FAIL d_rearm: got %h want 8000", term_in_dsr); end
    disp_rdy = 1'b1; tick(1); disp_rdy = 1'b0;
    checks++; if (disp_vld !== 1'b0) begin errors++; $display("FAIL d_pop: vld=%b want 0", disp_vld); end
  endtask

  task automatic test_disp_full;
    bit ok;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      core_write(8'h30 + 8'(i), ok);
      checks++; if (!ok) begin errors++; $display("FAIL df_write%0d: handshake timeout, got 0 want 1", i); end
    end
    tick(20);
    checks++; if (disp_level !== 4'd8) begin errors++; $display("FAIL df_level: got %0d want 8", disp_level); end
    checks++; if (term_in_dsr !== 16'h0000) begin errors++; $display("FAIL df_backpressure: got %h want 0000", term_in_dsr); end
    checks++; if (disp_data !== 8'h30) begin errors++; $display("FAIL df_head: got %h want 30", disp_data); end
    disp_rdy = 1'b1; tick(1); disp_rdy = 1'b0;
    checks++; if (disp_level !== 4'd7 || disp_data !== 8'h31) begin errors++; $display("FAIL df_pop1: level=%0d data=%h want 7/31", disp_level, disp_data); end
    core_write(8'h38, ok);
    checks++; if (!ok || disp_level !== 4'd8) begin errors++; $display("FAIL df_ninth: ok=%b level=%0d want 1/8", ok, disp_level); end
    for (int i = 0; i < 8; i++) begin
      exp = 8'h31 + 8'(i);
      checks++; if (disp_vld !== 1'b1 || disp_data !== exp) begin errors++; $display("FAIL df_drain%0d: vld=%b data=%h want 1/%h", i, disp_vld, disp_data, exp); end
      disp_rdy = 1'b1; tick(1); disp_rdy = 1'b0;
    end
    checks++; if (disp_vld !== 1'b0 || disp_level !== 4'd0) begin errors++; $display("FAIL df_empty: vld=%b level=%0d want 0/0", disp_vld, disp_level); end
  endtask

  task automatic test_key_full;
    logic [7:0] c;
    bit ok;
    for (int i = 0; i < 8; i++) begin key_vld = 1'b1; key_data = 8'h70 + 8'(i); tick(1); end
    checks++; if (key_level !== 4'd8 || key_rdy !== 1'b0) begin errors++; $display("FAIL kf_full: level=%0d rdy=%b want 8/0", key_level, key_rdy); end
    key_data = 8'hEE; tick(3);
    checks++; if (key_level !== 4'd8 || key_rdy !== 1'b0) begin errors++; $display("FAIL kf_no_push: level=%0d rdy=%b want 8/0", key_level, key_rdy); end
    key_vld = 1'b0;
    wait_offer(c, ok);
    checks++; if (!ok || c !== 8'h70) begin errors++; $display("FAIL kf_head: got %h want 70", c); end
    cpu_kbsr = 16'h8000; tick(5);
    checks++; if (key_level !== 4'd7 || key_rdy !== 1'b1) begin errors++; $display("FAIL kf_pop: level=%0d rdy=%b want 7/1", key_level, key_rdy); end
    cpu_kbsr = 16'h0000; tick(3);
    wait_offer(c, ok);
    checks++; if (!ok || c !== 8'h71) begin errors++; $display("FAIL kf_second: got %h want 71", c); end
    cpu_kbsr = 16'h8000; tick(2);
    key_vld = 1'b1; key_data = 8'h99; tick(1); key_vld = 1'b0;
    checks++; if (key_level !== 4'd7 || term_kbdr[15] !== 1'b0) begin errors++; $display("FAIL kf_push_pop: level=%0d stb=%b want 7/0", key_level, term_kbdr[15]); end
    cpu_kbsr = 16'h0000; tick(3);
  endtask

  task automatic test_reset_mid;
    logic [7:0] c;
    bit ok;
    wait_offer(c, ok);
    checks++; if (!ok || c !== 8'h72) begin errors++; $display("FAIL rm_offer: got %h want 72", c); end
    wait_dsr(1'b1, ok);
    cpu_ddr = 16'h005A; cpu_out_dsr = 16'h0000;
    wait_dsr(1'b0, ok);
    checks++; if (!ok || disp_level !== 4'd1) begin errors++; $display("FAIL rm_dack: level=%0d want 1", disp_level); end
    rst_n = 1'b0; #1;
    checks++; if (term_kbdr !== 16'h0000 || term_in_dsr !== 16'h0000) begin errors++; $display("FAIL rm_regs: kbdr=%h dsr=%h want 0000/0000", term_kbdr, term_in_dsr); end
    checks++; if (key_level !== 4'd0 || disp_level !== 4'd0 || disp_vld !== 1'b0) begin errors++; $display("FAIL rm_levels: kl=%0d dl=%0d vld=%b want 0/0/0", key_level, disp_level, disp_vld); end
    tick(2); rst_n = 1'b1; tick(10);
    checks++; if (term_in_dsr !== 16'h0000 || disp_level !== 4'd0) begin errors++; $display("FAIL rm_stale: dsr=%h dl=%0d want 0000/0", term_in_dsr, disp_level); end
    checks++; if (term_kbdr !== 16'h0000 || key_level !== 4'd0) begin errors++; $display("FAIL rm_kbd_idle: kbdr=%h kl=%0d want 0000/0", term_kbdr, key_level); end
    cpu_out_dsr = 16'h8000; tick(4);
    checks++; if (term_in_dsr !== 16'h8000 || disp_level !== 4'd0) begin errors++; $display("FAIL rm_recover: dsr=%h dl=%0d want 8000/0", term_in_dsr, disp_level); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_back_to_back();
    test_display();
    test_disp_full();
    test_key_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
